// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Hazard and forwarding controller for an in-order rv32
//               pipeline. A per-register scoreboard records how many stages
//               each in-flight producer is ahead of decode. From it the block
//               derives the operand forwarding selects and the load-use stall
//               for the instruction in decode. It also stretches a taken
//               branch or jump into a flush of FLUSH_CYC cycles.
//
// Parameters  : NREG      number of architectural registers
//               DEPTH     stages from issue to register-file write, inclusive
//               LOAD_LAT  age at which a load result becomes forwardable
//               FLUSH_CYC cycles of flush per redirect
//
// Ports       : clk, rst           clock and synchronous active-high reset
//               issue_*            decode-stage instruction description
//               redirect           taken branch/jump resolved in EXE
//               stall, flush       pipeline control outputs
//               fwd_sel_a/b        0 = register file, k = producer k ahead
//               stall_cnt          stall cycles counted (stats build only)
//               flush_cnt          redirects counted (stats build only)
//
// Build macro : HAZARD_STATS_EN    builds the stall/flush statistics counters;
//                                  when undefined both counters read 0.
//
// Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREG      = 32,
    parameter int DEPTH     = 3,
    parameter int LOAD_LAT  = 2,
    parameter int FLUSH_CYC = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic [$clog2(NREG)-1:0]    issue_rd,
    input  logic                       issue_we,
    input  logic                       issue_is_load,
    input  logic [$clog2(NREG)-1:0]    issue_rs1,
    input  logic [$clog2(NREG)-1:0]    issue_rs2,
    input  logic                       issue_use_rs1,
    input  logic                       issue_use_rs2,
    input  logic                       redirect,
    output logic                       stall,
    output logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] fwd_sel_a,
    output logic [$clog2(DEPTH+1)-1:0] fwd_sel_b,
    output logic [31:0]                stall_cnt,
    output logic [31:0]                flush_cnt
);

    localparam int c_AW = $clog2(NREG);
    localparam int c_SW = $clog2(DEPTH + 1);
    localparam int c_FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [c_SW-1:0] c_DEPTH      = c_SW'(DEPTH);
    // One extra bit so LOAD_LAT = DEPTH + 1 is still representable.
    localparam logic [c_SW:0]   c_LOAD_LAT   = (c_SW + 1)'(LOAD_LAT);
    localparam logic [c_FW-1:0] c_FLUSH_LOAD = c_FW'(FLUSH_CYC - 1);

    // Scoreboard: age 0 means no write in flight for that register.
    logic [c_SW-1:0] r_age [NREG];
    logic [NREG-1:0] r_ld;
    logic [c_FW-1:0] r_fcnt;

    logic [c_SW-1:0] w_sel_a;
    logic [c_SW-1:0] w_sel_b;
    logic            w_ld_a;
    logic            w_ld_b;
    logic            w_haz_a;
    logic            w_haz_b;
    logic            w_flush;
    logic            w_stall;
    logic            w_fire;

    // ------------------------------------------------------------------------
    // Forwarding selects, hazard detection and issue qualification
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_ld_a  = r_ld[issue_rs1];
        w_ld_b  = r_ld[issue_rs2];

        if (issue_use_rs1 && (issue_rs1 != '0)) begin
            w_sel_a = r_age[issue_rs1];
        end
        if (issue_use_rs2 && (issue_rs2 != '0)) begin
            w_sel_b = r_age[issue_rs2];
        end

        // A load still younger than LOAD_LAT has no forwardable data yet.
        w_haz_a = (w_sel_a != '0) && w_ld_a && ({1'b0, w_sel_a} < c_LOAD_LAT);
        w_haz_b = (w_sel_b != '0) && w_ld_b && ({1'b0, w_sel_b} < c_LOAD_LAT);

        // Outputs are held quiet while reset is asserted, whatever the inputs.
        w_flush = ~rst & (redirect | (r_fcnt != '0));
        w_stall = ~rst & issue_valid & ~w_flush & ~redirect & (w_haz_a | w_haz_b);
        w_fire  = issue_valid & ~w_stall & ~w_flush & ~redirect;
    end

    assign stall     = w_stall;
    assign flush     = w_flush;
    assign fwd_sel_a = rst ? '0 : w_sel_a;
    assign fwd_sel_b = rst ? '0 : w_sel_b;

    // ------------------------------------------------------------------------
    // Scoreboard aging and flush counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_age[r] <= '0;
            end
            r_ld   <= '0;
            r_fcnt <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                // A new producer replaces any older one for the same register.
                // Register 0 never matches, so its entry stays empty.
                if (w_fire && issue_we && (issue_rd != '0) && (issue_rd == c_AW'(r))) begin
                    r_age[r] <= c_SW'(1);
                    r_ld[r]  <= issue_is_load;
                end else if (r_age[r] == c_DEPTH) begin
                    r_age[r] <= '0;
                    r_ld[r]  <= 1'b0;
                end else if (r_age[r] != '0) begin
                    r_age[r] <= r_age[r] + c_SW'(1);
                end
            end

            // The redirect cycle itself flushes combinationally; the counter
            // covers the remaining FLUSH_CYC - 1 cycles.
            if (redirect) begin
                r_fcnt <= c_FLUSH_LOAD;
            end else if (r_fcnt != '0) begin
                r_fcnt <= r_fcnt - c_FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (redirect) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed testbench for hazard_scoreboard (DEPTH 3, LOAD_LAT 2,
//               FLUSH_CYC 3). Each stimulus cycle queues its hand-computed
//               expected outputs; a monitor on the falling edge pops and
//               compares them against the DUT.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       issue_we;
    logic       issue_is_load;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic       issue_use_rs1;
    logic       issue_use_rs2;
    logic       redirect;
    logic       stall;
    logic       flush;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    hazard_scoreboard #(
        .NREG      (32),
        .DEPTH     (3),
        .LOAD_LAT  (2),
        .FLUSH_CYC (3)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_we      (issue_we),
        .issue_is_load (issue_is_load),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .redirect      (redirect),
        .stall         (stall),
        .flush         (flush),
        .fwd_sel_a     (fwd_sel_a),
        .fwd_sel_b     (fwd_sel_b),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    typedef struct {
        int          id;
        logic        stall;
        logic        flush;
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks  = 0;
    int          errors  = 0;
    int          step_id = 0;
    logic [31:0] tally_stall = 0;
    logic [31:0] tally_flush = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle, compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stall",     e.id, {31'd0, stall},     {31'd0, e.stall});
            chk("flush",     e.id, {31'd0, flush},     {31'd0, e.flush});
            chk("fwd_sel_a", e.id, {30'd0, fwd_sel_a}, {30'd0, e.sel_a});
            chk("fwd_sel_b", e.id, {30'd0, fwd_sel_b}, {30'd0, e.sel_b});
            chk("stall_cnt", e.id, stall_cnt,          e.scnt);
            chk("flush_cnt", e.id, flush_cnt,          e.fcnt);
        end
    end

    task automatic step(
        input logic       t_rst,
        input logic       t_v,
        input logic [4:0] t_rd,
        input logic       t_we,
        input logic       t_ld,
        input logic [4:0] t_rs1,
        input logic       t_u1,
        input logic [4:0] t_rs2,
        input logic       t_u2,
        input logic       t_redir,
        input logic       e_stall,
        input logic       e_flush,
        input logic [1:0] e_a,
        input logic [1:0] e_b
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst           = t_rst;
        issue_valid   = t_v;
        issue_rd      = t_rd;
        issue_we      = t_we;
        issue_is_load = t_ld;
        issue_rs1     = t_rs1;
        issue_use_rs1 = t_u1;
        issue_rs2     = t_rs2;
        issue_use_rs2 = t_u2;
        redirect      = t_redir;
        step_id++;
        e.id    = step_id;
        e.stall = e_stall;
        e.flush = e_flush;
        e.sel_a = e_a;
        e.sel_b = e_b;
`ifdef HAZARD_STATS_EN
        // Counters are registered: this cycle shows the count of earlier cycles.
        e.scnt = tally_stall;
        e.fcnt = tally_flush;
        if (t_rst) begin
            tally_stall = 0;
            tally_flush = 0;
        end else begin
            tally_stall = tally_stall + {31'd0, e_stall};
            tally_flush = tally_flush + {31'd0, t_redir};
        end
`else
        e.scnt = 32'd0;
        e.fcnt = 32'd0;
`endif
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_rd = '0; issue_we = 1'b0;
        issue_is_load = 1'b0; issue_rs1 = '0; issue_rs2 = '0;
        issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0; redirect = 1'b0;

        //   rst v  rd we ld rs1 u1 rs2 u2 rd  | stall flush a b
        // Reset with arbitrary inputs
        step(1, 1,  5, 1, 1,  5, 1,  7, 1, 1,   0, 0, 0, 0);
        step(1, 1,  9, 1, 0,  9, 1,  9, 1, 0,   0, 0, 0, 0);
        // ALU chain on x5
        step(0, 1,  5, 1, 0,  1, 1,  2, 1, 0,   0, 0, 0, 0);
        step(0, 1,  0, 0, 0,  5, 1,  0, 0, 0,   0, 0, 1, 0);
        step(0, 0,  0, 0, 0,  5, 1,  0, 0, 0,   0, 0, 2, 0);
        step(0, 1,  0, 0, 0,  5, 1,  0, 0, 0,   0, 0, 3, 0);
        step(0, 1,  0, 0, 0,  5, 1,  0, 0, 0,   0, 0, 0, 0);
        // Load-use on x7: one stall cycle, then forward from age 2
        step(0, 1,  7, 1, 1,  0, 1,  0, 0, 0,   0, 0, 0, 0);
        step(0, 1,  0, 0, 0,  0, 0,  7, 1, 0,   1, 0, 0, 1);
        step(0, 1,  0, 0, 0,  0, 0,  7, 1, 0,   0, 0, 0, 2);
        step(0, 0,  0, 0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 0);
        // Youngest wins on x3: add overrides the load
        step(0, 1,  3, 1, 1,  0, 0,  0, 0, 0,   0, 0, 0, 0);
        step(0, 1,  3, 1, 0,  0, 0,  0, 0, 0,   0, 0, 0, 0);
        step(0, 1,  0, 0, 0,  3, 1,  3, 1, 0,   0, 0, 1, 1);
        step(0, 0,  0, 0, 0,  0, 0,  0, 0, 0,   0, 0, 0, 0);
        step(0, 0,  0, 0, 0,  3, 1,  0, 0, 0,   0, 0, 3, 0);
        step(0, 1,  0, 0, 0,  3, 1,  3, 1, 0,   0, 0, 0, 0);
        // x0 is never tracked
        step(0, 1,  0, 1, 0,  0, 0,  0, 0, 0,   0, 0, 0, 0);
        step(0, 1,  0, 0, 0,  0, 1,  0, 1, 0,   0, 0, 0, 0);
        // Redirect over a load-use hazard, second redirect extends the flush
        step(0, 1,  9, 1, 1,  0, 0,  0, 0, 0,   0, 0, 0, 0);
        step(0, 1, 10, 1, 0,  9, 1,  0, 0, 1,   0, 1, 1, 0);
        step(0, 1, 11, 1, 0, 10, 1,  9, 1, 1,   0, 1, 0, 2);
        step(0, 1, 12, 1, 0, 11, 1,  0, 0, 0,   0, 1, 0, 0);
        step(0, 1,  0, 0, 0, 12, 1,  0, 0, 0,   0, 1, 0, 0);
        step(0, 1, 13, 1, 1, 12, 1,  9, 1, 0,   0, 0, 0, 0);
        step(0, 1,  0, 0, 0, 13, 1,  0, 0, 0,   1, 0, 1, 0);
        step(0, 1,  0, 0, 0, 13, 1,  0, 0, 0,   0, 0, 2, 0);
        // Reset mid-operation discards the pending load on x14
        step(0, 1, 14, 1, 1,  0, 0,  0, 0, 0,   0, 0, 0, 0);
        step(1, 1,  0, 0, 0, 14, 1, 14, 1, 1,   0, 0, 0, 0);
        step(0, 1,  0, 0, 0, 14, 1, 14, 1, 0,   0, 0, 0, 0);

        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding controller for the rv32 in-order pipeline.
- Keeps a per-register scoreboard of in-flight writes, identified by how far each producer is ahead of the decode stage.
- Generates per-operand forwarding selects and load-use stalls for the instruction in decode.
- Generates a multi-cycle front-end flush on a taken branch or jump.
- Generalises the fixed EXE/ACC-only forwarding manager to arbitrary pipeline depth, load latency and flush length.

Parameters:
NREG, 32, number of architectural registers; AW = $clog2(NREG) is the register address width.
DEPTH, 3, number of stages from issue (decode→exe) to the write-back register-file write, inclusive.
LOAD_LAT, 2, a load result can be forwarded once the producer is this many stages ahead (2 = from ACC output).
FLUSH_CYC, 1, number of cycles flush stays asserted after a redirect.
SW = $clog2(DEPTH+1), width of forwarding selects and age counters.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  decode holds a valid instruction
issue_rd  in  AW  destination register
issue_we  in  1  instruction writes rd
issue_is_load  in  1  instruction is a load
issue_rs1  in  AW  source register 1
issue_rs2  in  AW  source register 2
issue_use_rs1  in  1  rs1 is read
issue_use_rs2  in  1  rs2 is read
redirect  in  1  taken branch/jump resolved in EXE this cycle
stall  out  1  hold PC and decode, insert bubble into EXE
flush  out  1  kill fetch/decode contents
fwd_sel_a  out  SW  rs1 source: 0 = register file, k = producer k stages ahead
fwd_sel_b  out  SW  rs2 source, same encoding
stall_cnt  out  32  stall cycles counted (see Optional Feature)
flush_cnt  out  32  redirects counted (see Optional Feature)

Behaviour:
Clocking and reset:
- Single clock.
- Reset is synchronous and active-high on rst; it is sampled on the clk rising edge.
- On reset: all age[] = 0, all ld[] = 0, flush counter = 0, stall = 0, flush = 0, fwd_sel_a/b = 0, stat counters = 0.
- Reset asserted mid-operation discards all pending entries the same edge.

Scoreboard state:
- Per register r: age[r] (SW bits) and ld[r] (1 bit).
- age 0 = no write in flight.

Issue and age update:
- fire = issue_valid & ~stall & ~flush & ~redirect.
- On the clock edge, each age[r] != 0 increments; an entry with age[r] == DEPTH clears to 0 and ld[r] clears to 0 (write committed).
- If fire & issue_we & issue_rd != 0: age[rd] <= 1, ld[rd] <= issue_is_load. This overrides that entry's aging, so the youngest producer wins.
- Register 0 is never tracked.

Forwarding and stall (combinational from current state and issue_* inputs):
- fwd_sel_x = 0 if the operand is unused, rs == 0, or age[rs] == 0; otherwise age[rs].
- Hazard on an operand: operand used, rs != 0, ld[rs] = 1, and 0 < age[rs] < LOAD_LAT.
- stall = issue_valid & ~flush & ~redirect & (hazard on rs1 or rs2).
- While stalled, no new entry is written and ages keep advancing, so the stall self-releases after LOAD_LAT − age cycles.

Flush:
- redirect forces flush = 1 combinationally the same cycle and loads the flush counter with FLUSH_CYC − 1.
- While the counter != 0, flush = 1 and the counter decrements each cycle.
- redirect during an active flush reloads the counter.
- redirect together with a stall: flush wins and stall = 0.
- In-flight entries older than the branch are unaffected.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined: stall_cnt increments every cycle with stall = 1; flush_cnt increments on every redirect. Both wrap at 2^32 and are cleared by rst.
- Undefined: stall_cnt and flush_cnt are constant 0 and no counter logic is built.

Test Plan:
1. Reset: hold rst for 2 cycles with arbitrary inputs → stall = 0, flush = 0, fwd_sel_a = fwd_sel_b = 0, all counters 0.
2. ALU chain: issue add x5; next cycle issue rs1 = x5 → fwd_sel_a = 1, stall = 0. One bubble later, rs1 = x5 → fwd_sel_a = 2. After DEPTH = 3 cycles → fwd_sel_a = 0.
3. Load-use: issue lw x7; next cycle rs2 = x7 → stall = 1 for exactly 1 cycle, then fwd_sel_b = 2 with stall = 0. With HAZARD_STATS_EN, stall_cnt = 1.
4. Youngest wins: issue lw x3, then add x3, then a consumer reading x3 → fwd_sel = 1 from the add, no stall. After DEPTH cycles, age[x3] = 0.
5. Redirect while decode holds a load-use hazard → flush = 1, stall = 0, no entry created. With FLUSH_CYC = 3, flush stays high 3 cycles, and a second redirect in cycle 2 extends it to cycle 4.
6. x0: issue add x0, then a consumer of x0 → fwd_sel = 0, stall = 0, scoreboard unchanged.
